// File: rtl/instr_fetch_mem_if.sv
// ----------------------------------------------------------------------------
// instr_fetch_mem_if
// Bus bundle between the fetch stage / program loader (master) and the
// instruction memory (slave).
//   Fetch request : req_valid, req_addr  (master -> slave), req_ready (slave -> master)
//   Fetch response: rsp_valid, rsp_data, rsp_fault (slave -> master), rsp_ready (master -> slave)
//   Program load  : ld_en, ld_addr, ld_data (master -> slave), ld_err (slave -> master)
// ----------------------------------------------------------------------------
interface instr_fetch_mem_if #(
    parameter int N             = 32,
    parameter int MEM_CELL_SIZE = 8
);
    logic                     req_valid;
    logic [N-1:0]             req_addr;
    logic                     req_ready;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [N-1:0]             rsp_data;
    logic                     rsp_fault;
    logic                     ld_en;
    logic [N-1:0]             ld_addr;
    logic [MEM_CELL_SIZE-1:0] ld_data;
    logic                     ld_err;

    modport master (
        output req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
        input  req_ready, rsp_valid, rsp_data, rsp_fault, ld_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
        output req_ready, rsp_valid, rsp_data, rsp_fault, ld_err
    );
endinterface

// File: rtl/instr_fetch_mem.sv
// ----------------------------------------------------------------------------
// instr_fetch_mem
// Byte-addressed instruction memory with a program-load port and a
// valid/ready fetch port. Words are assembled big-endian from BPW cells and
// returned one registered cycle after a request is accepted. After every
// reset the whole array is swept to zero, one word per cycle, before fetches
// and loads are accepted.
// Ports:
//   clk        clock, rising edge
//   rstn       asynchronous active-low reset
//   bus        slave side of instr_fetch_mem_if (fetch req/rsp + load port)
//   init_done  high once the clear sweep has finished
// ----------------------------------------------------------------------------
module instr_fetch_mem #(
    parameter int N             = 32,
    parameter int MEM_CELL_SIZE = 8,
    parameter int INST_MEM_SIZE = 256
) (
    input  logic             clk,
    input  logic             rstn,
    instr_fetch_mem_if.slave bus,
    output logic             init_done
);
    localparam int BPW   = N / MEM_CELL_SIZE;
    localparam int WORDS = INST_MEM_SIZE / BPW;
    localparam int AW    = $clog2(INST_MEM_SIZE);
    localparam int WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;

    // Full-width constants so range checks never truncate the incoming address.
    localparam logic [N-1:0]   MEM_LIMIT  = N'(INST_MEM_SIZE);
    localparam logic [N-1:0]   ALIGN_MASK = N'(BPW - 1);
    localparam logic [WCW-1:0] LAST_WORD  = WCW'(WORDS - 1);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [WCW-1:0]           wcnt_q, wcnt_d;
    logic                     init_done_q, init_done_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [N-1:0]             rsp_data_q, rsp_data_d;
    logic                     rsp_fault_q, rsp_fault_d;
    logic                     ld_err_q, ld_err_d;

    // Storage array: deliberately not reset, contents come from the INIT sweep.
    logic [MEM_CELL_SIZE-1:0] mem_q [INST_MEM_SIZE];

    logic                     ready_s;
    logic                     req_ready_s;
    logic                     accept_s;
    logic                     misaligned_s;
    logic                     out_of_range_s;
    logic                     fault_s;
    logic                     ld_ok_s;
    logic                     clr_en_s;
    logic [N-1:0]             rd_word_s;

    assign ready_s        = (state_q == ST_READY);
    assign req_ready_s    = ready_s && (!rsp_valid_q || bus.rsp_ready);
    assign accept_s       = bus.req_valid && req_ready_s;
    assign misaligned_s   = ((bus.req_addr & ALIGN_MASK) != '0);
    assign out_of_range_s = (bus.req_addr >= MEM_LIMIT);
    assign fault_s        = misaligned_s || out_of_range_s;
    assign clr_en_s       = (state_q == ST_INIT);
    assign ld_ok_s        = bus.ld_en && ready_s && (bus.ld_addr < MEM_LIMIT);

    // Next-state logic for the clear sweep FSM and the init_done flag.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_INIT: begin
                if (wcnt_q == LAST_WORD) begin
                    state_d     = ST_READY;
                    wcnt_d      = '0;
                    init_done_d = 1'b1;
                end else begin
                    wcnt_d      = wcnt_q + WCW'(1);
                end
            end
            ST_READY: begin
                state_d     = ST_READY;
                init_done_d = 1'b1;
            end
            default: begin
                state_d     = ST_INIT;
                wcnt_d      = '0;
                init_done_d = 1'b0;
            end
        endcase
    end

    // Big-endian assembly of the addressed word; reads the pre-edge array so a
    // same-cycle load is not visible (read-before-write). Index wraps harmlessly
    // for faulting addresses because the result is then discarded.
    always_comb begin
        rd_word_s = '0;
        for (int b = 0; b < BPW; b++) begin
            rd_word_s[N-1-b*MEM_CELL_SIZE -: MEM_CELL_SIZE] =
                mem_q[bus.req_addr[AW-1:0] + AW'(b)];
        end
    end

    // Response register: load on accept, drop when consumed, hold while stalled.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_fault_d = rsp_fault_q;
        if (accept_s) begin
            rsp_valid_d = 1'b1;
            rsp_fault_d = fault_s;
            rsp_data_d  = fault_s ? '0 : rd_word_s;
        end else if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

    // A load is dropped while clearing or when it targets a cell beyond the array.
    always_comb begin
        ld_err_d = 1'b0;
        if (bus.ld_en && !ld_ok_s) begin
            ld_err_d = 1'b1;
        end else begin
            ld_err_d = 1'b0;
        end
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_INIT;
            wcnt_q      <= '0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_fault_q <= 1'b0;
            ld_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            init_done_q <= init_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_fault_q <= rsp_fault_d;
            ld_err_q    <= ld_err_d;
        end
    end

    // Array writes: one whole word zeroed per INIT cycle, otherwise program loads.
    always_ff @(posedge clk) begin
        if (clr_en_s) begin
            for (int b = 0; b < BPW; b++) begin
                mem_q[AW'(int'(wcnt_q) * BPW + b)] <= '0;
            end
        end else if (ld_ok_s) begin
            mem_q[bus.ld_addr[AW-1:0]] <= bus.ld_data;
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_fault = rsp_fault_q;
    assign bus.ld_err    = ld_err_q;
    assign init_done     = init_done_q;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_mem
// Self-checking bench for instr_fetch_mem. A cycle model (memory image,
// response-valid, INIT countdown, ld_err) predicts the handshake outputs every
// cycle; expected responses are queued when a request is accepted and checked
// when the response is held or consumed. A table of vectors with hand-written
// expected words covers loads and the fault cases; short sequences cover INIT,
// back-pressure, read-before-write and mid-operation reset.
// ----------------------------------------------------------------------------
module tb_instr_fetch_mem;
    logic clk = 1'b0;
    logic rstn;
    logic init_done;

    instr_fetch_mem_if #(.N(32), .MEM_CELL_SIZE(8)) bus ();

    instr_fetch_mem #(.N(32), .MEM_CELL_SIZE(8), .INST_MEM_SIZE(256)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        fault;
    } exp_t;

    typedef struct {
        logic        req_valid;
        logic [31:0] req_addr;
        logic        ld_en;
        logic [31:0] ld_addr;
        logic [7:0]  ld_data;
        logic [31:0] exp_data;
        logic        exp_fault;
    } vec_t;

    exp_t       sb[$];
    vec_t       tab[12];
    logic [7:0] mem_m [256];
    logic       ready_m;
    logic       rsp_valid_m;
    logic       ld_err_m;
    int         init_cnt;
    logic       use_tab;
    exp_t       tab_exp;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_fetch(input logic [31:0] a);
        exp_t e;
        logic [7:0] i;
        i = a[7:0];
        if (a[1:0] != 2'b00 || a >= 32'd256) begin
            e.data  = 32'h0;
            e.fault = 1'b1;
        end else begin
            e.data  = {mem_m[i], mem_m[i + 8'd1], mem_m[i + 8'd2], mem_m[i + 8'd3]};
            e.fault = 1'b0;
        end
        return e;
    endfunction

    // One clock cycle: inputs are already set at the negedge; check, then
    // advance the model across the coming posedge.
    task automatic tick();
        logic exp_rr;
        logic acc;
        exp_t e;
        #1;
        exp_rr = ready_m && (!rsp_valid_m || bus.rsp_ready);
        chk("req_ready", {31'd0, bus.req_ready}, {31'd0, exp_rr});
        chk("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, rsp_valid_m});
        chk("ld_err", {31'd0, bus.ld_err}, {31'd0, ld_err_m});
        chk("init_done", {31'd0, init_done}, {31'd0, ready_m});
        if (rsp_valid_m) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_empty: response present with no expected entry at %0t", $time);
            end else begin
                if (bus.rsp_ready) e = sb.pop_front();
                else               e = sb[0];
                chk("rsp_data", bus.rsp_data, e.data);
                chk("rsp_fault", {31'd0, bus.rsp_fault}, {31'd0, e.fault});
            end
        end
        acc = bus.req_valid && exp_rr;
        if (acc) begin
            if (use_tab) sb.push_back(tab_exp);
            else         sb.push_back(model_fetch(bus.req_addr));
        end
        ld_err_m = bus.ld_en && (!ready_m || bus.ld_addr >= 32'd256);
        if (bus.ld_en && ready_m && bus.ld_addr < 32'd256) mem_m[bus.ld_addr[7:0]] = bus.ld_data;
        rsp_valid_m = acc ? 1'b1 : (bus.rsp_ready ? 1'b0 : rsp_valid_m);
        if (!ready_m) begin
            init_cnt++;
            if (init_cnt == 64) ready_m = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn          = 1'b0;
        bus.req_valid = 1'b0;
        bus.ld_en     = 1'b0;
        #1;
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_rsp_fault", {31'd0, bus.rsp_fault}, 32'd0);
        chk("rst_ld_err", {31'd0, bus.ld_err}, 32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        sb.delete();
        for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
        ready_m     = 1'b0;
        rsp_valid_m = 1'b0;
        ld_err_m    = 1'b0;
        init_cnt    = 0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          rv    req_addr      ld    ld_addr      ld_data  exp_data       exp_fault
        tab[0]  = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_0004, 8'h04, 32'h0000_0000, 1'b0};
        tab[1]  = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_0005, 8'h01, 32'h0000_0000, 1'b0};
        tab[2]  = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_0006, 8'h18, 32'h0000_0000, 1'b0};
        tab[3]  = '{1'b1, 32'h0000_0000, 1'b1, 32'h0000_0007, 8'h00, 32'h0000_0000, 1'b0};
        tab[4]  = '{1'b1, 32'h0000_0004, 1'b0, 32'h0000_0000, 8'h00, 32'h0401_1800, 1'b0};
        tab[5]  = '{1'b1, 32'h0000_0005, 1'b0, 32'h0000_0000, 8'h00, 32'h0000_0000, 1'b1};
        tab[6]  = '{1'b1, 32'h0000_0100, 1'b0, 32'h0000_0000, 8'h00, 32'h0000_0000, 1'b1};
        tab[7]  = '{1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 8'h00, 32'h0000_0000, 1'b1};
        tab[8]  = '{1'b1, 32'h0000_00FC, 1'b1, 32'h0000_0100, 8'h55, 32'h0000_0000, 1'b0};
        tab[9]  = '{1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 8'h00, 32'h0000_0000, 1'b0};
        tab[10] = '{1'b1, 32'h0000_0004, 1'b0, 32'h0000_0000, 8'h00, 32'h0401_1800, 1'b0};
        tab[11] = '{1'b1, 32'h0000_0006, 1'b0, 32'h0000_0000, 8'h00, 32'h0000_0000, 1'b1};

        use_tab       = 1'b0;
        tab_exp       = '{32'h0, 1'b0};
        rstn          = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'h0;
        bus.rsp_ready = 1'b1;
        bus.ld_en     = 1'b0;
        bus.ld_addr   = 32'h0;
        bus.ld_data   = 8'h00;
        #3;
        do_reset();

        // INIT: request held high is refused for 64 cycles; a load is dropped.
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0;
        for (int c = 0; c < 64; c++) begin
            bus.ld_en   = (c == 10);
            bus.ld_addr = 32'h10;
            bus.ld_data = 8'h33;
            tick();
        end
        bus.ld_en = 1'b0;
        tick();
        bus.req_addr = 32'hFC;
        tick();
        bus.req_valid = 1'b0;
        tick();

        // Table of loads and fetches with hand-computed expected words.
        use_tab = 1'b1;
        for (int v = 0; v < 12; v++) begin
            bus.req_valid = tab[v].req_valid;
            bus.req_addr  = tab[v].req_addr;
            bus.ld_en     = tab[v].ld_en;
            bus.ld_addr   = tab[v].ld_addr;
            bus.ld_data   = tab[v].ld_data;
            tab_exp       = '{tab[v].exp_data, tab[v].exp_fault};
            tick();
        end
        use_tab       = 1'b0;
        bus.req_valid = 1'b0;
        bus.ld_en     = 1'b0;
        tick();
        tick();

        // Back-pressure: response held 3 cycles, then a back-to-back stream.
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h04;
        tick();
        bus.req_addr  = 32'h00;
        bus.rsp_ready = 1'b0;
        repeat (3) tick();
        bus.rsp_ready = 1'b1;
        tick();
        bus.req_addr = 32'h04;
        tick();
        bus.req_addr = 32'h08;
        tick();
        bus.req_valid = 1'b0;
        tick();

        // Same-cycle load and fetch of one word: old data first, new data next.
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h08;
        bus.ld_en     = 1'b1;
        bus.ld_addr   = 32'h08;
        bus.ld_data   = 8'hAA;
        tick();
        bus.ld_en = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        tick();

        // Reset while a response is pending and the array holds program data.
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h04;
        bus.rsp_ready = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        #3;
        do_reset();
        bus.rsp_ready = 1'b1;
        repeat (64) tick();
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h04;
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
